rr_read_arbiter: RTL and testbench
==================================

Name: rr_read_arbiter

Overview:
- Parametrised round-robin read arbiter between NUM_CHANNELS strip drivers and the single read port of the frame BRAM.
- Successor to the fixed 8-channel bus arbiter: channel count, widths and BRAM read latency are parameters.
- Issues one pipelined read per cycle, holds a registered per-channel data buffer, and provides per-channel enable masking.
- Sits between the strip_driver instances and the bram read port, in the clk_50mhz domain.

Parameters:
- NUM_CHANNELS, 8: number of requesting strip drivers (1..16).
- ADDRESS_WIDTH, 13: BRAM address width.
- DATA_WIDTH, 8: BRAM data width.
- MEM_LATENCY, 1: edges from mem_raddr/mem_re registered to mem_rdata valid for capture (1..4).

Ports:
- clk  input  1  system clock (clk_50mhz)
- resetn  input  1  asynchronous active-low reset
- chan_enable  input  NUM_CHANNELS  per-channel grant enable
- data_req  input  NUM_CHANNELS  per-channel read request, level
- data_addr  input  NUM_CHANNELS*ADDRESS_WIDTH  flattened request addresses; channel k at [k*AW +: AW]
- data  output  NUM_CHANNELS*DATA_WIDTH  flattened per-channel read-data buffers
- data_rdy  output  NUM_CHANNELS  one-cycle completion pulse per channel
- mem_re  output  1  BRAM read enable
- mem_raddr  output  ADDRESS_WIDTH  BRAM read address
- mem_rdata  input  DATA_WIDTH  BRAM read data

Behaviour:
- Reset (resetn low, async): data_rdy=0, data=0, mem_re=0, mem_raddr=0, pending mask=0, pipeline valid bits=0, rr pointer=0.
- Eligible(k) = data_req[k] & chan_enable[k] & ~pending[k] & ~data_rdy[k].
- Arbitration (combinational): search from pointer upward with wrap. First eligible channel g wins.
- Grant edge E0: mem_raddr <= addr of g, mem_re <= 1, pending[g] <= 1, pointer <= (g+1) mod NUM_CHANNELS.
- Push {valid=1, idx=g} into a MEM_LATENCY-deep tag pipeline.
- No eligible channel: mem_re <= 0, mem_raddr holds, pointer holds, push valid=0.
- Capture edge E0+MEM_LATENCY, tag valid for channel k: data[k] <= mem_rdata, data_rdy[k] <= 1 for exactly one cycle, pending[k] <= 0.
- Other channels' data buffers hold their values.
- Throughput: one grant per cycle across channels.
- Per channel: at most one outstanding read; next grant no earlier than the cycle after data_rdy[k].
- Latency: req high before E0 with no contention -> data_rdy high during cycle after E0+MEM_LATENCY.
- Requester contract: data_addr[k] stable while req high until data_rdy[k]. It may drop req, or present a new address with req high, in the data_rdy cycle.
- Simultaneous capture of k and grant of another channel in the same edge: both occur.
- data_rdy never has more than one bit set.
- chan_enable[k] deasserted while pending[k]: in-flight read still completes with data_rdy. No new grants to k.
- All channels disabled or idle: mem_re stays 0. The pointer freezes.
- Reset mid-operation: in-flight tags are discarded. No data_rdy for pre-reset reads after release.
- Pointer arithmetic wraps modulo NUM_CHANNELS, including non-power-of-2 values.

Test Plan:
- Single request, MEM_LATENCY=1: ch3 req, addr 0x123 -> mem_raddr=0x123, mem_re=1 after next edge. data_rdy[3] one cycle later, data[3]=mem_rdata.
- All 8 channels req at once, all enabled -> grants 0,1,...,7 on 8 consecutive edges. data_rdy pulses 0..7 in order, one per cycle, no gaps.
- ch0 held high continuously (new addr each rdy), ch5 held high -> grants alternate 0,5,0,5. Neither starves; ch0 never granted in its own rdy cycle.
- MEM_LATENCY=3, NUM_CHANNELS=5: channels 0..4 back-to-back -> 5 reads in flight overlapped. Each data_rdy lands 3 edges after its grant with correct data routing. Pointer wraps 4->0.
- Reset asserted with 2 reads in flight -> outputs 0 immediately (async). No data_rdy after release until new requests.
- chan_enable[2]=0 with ch2 and ch6 requesting -> only ch6 granted. Disable ch6 while pending -> its data_rdy still fires; no regrant.

Source files
------------

// File: rtl/rr_read_arbiter.sv
// Round-robin arbiter sharing one pipelined BRAM read port among NUM_CHANNELS
// requesters, with per-channel enable masking and registered read-data buffers.
module rr_read_arbiter #(
  parameter int NUM_CHANNELS  = 8,
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_LATENCY   = 1
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic [NUM_CHANNELS-1:0]              chan_enable,
  input  logic [NUM_CHANNELS-1:0]              data_req,
  input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] data_addr,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   data,
  output logic [NUM_CHANNELS-1:0]              data_rdy,
  output logic                                 mem_re,
  output logic [ADDRESS_WIDTH-1:0]             mem_raddr,
  input  logic [DATA_WIDTH-1:0]                mem_rdata
);

  localparam int PW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0]            pending_q, pending_d;
  logic [NUM_CHANNELS-1:0]            data_rdy_q, data_rdy_d;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_q, data_d;
  logic                               mem_re_q, mem_re_d;
  logic [ADDRESS_WIDTH-1:0]           mem_raddr_q, mem_raddr_d;
  logic [PW-1:0]                      ptr_q, ptr_d;
  logic [MEM_LATENCY-1:0]             tag_valid_q, tag_valid_d;
  logic [PW-1:0]                      tag_idx_q [MEM_LATENCY];
  logic [PW-1:0]                      tag_idx_d [MEM_LATENCY];

  logic [NUM_CHANNELS-1:0] eligible;
  logic                    grant_valid;
  logic [PW-1:0]           grant_idx;
  logic [PW-1:0]           cand;
  logic                    cap_valid;
  logic [PW-1:0]           cap_idx;

  // A channel is blocked while its read is in flight and during its rdy cycle.
  assign eligible  = data_req & chan_enable & ~pending_q & ~data_rdy_q;
  assign cap_valid = tag_valid_q[MEM_LATENCY-1];
  assign cap_idx   = tag_idx_q[MEM_LATENCY-1];

  // Scan from the pointer downward-in-priority so the last hit is the first
  // eligible channel at or after the pointer.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      cand = PW'((int'(ptr_q) + i) % NUM_CHANNELS);
      if (eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    pending_d   = pending_q;
    data_rdy_d  = '0;
    data_d      = data_q;
    mem_re_d    = 1'b0;
    mem_raddr_d = mem_raddr_q;
    ptr_d       = ptr_q;
    tag_valid_d = '0;
    for (int s = 0; s < MEM_LATENCY; s++) tag_idx_d[s] = '0;

    if (cap_valid) begin
      data_rdy_d[cap_idx] = 1'b1;
      pending_d[cap_idx]  = 1'b0;
      data_d[int'(cap_idx)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
    end

    // The granted channel is never the captured one: a captured channel was pending.
    if (grant_valid) begin
      mem_re_d             = 1'b1;
      mem_raddr_d          = data_addr[int'(grant_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      pending_d[grant_idx] = 1'b1;
      ptr_d = (grant_idx == PW'(NUM_CHANNELS - 1)) ? '0 : grant_idx + PW'(1);
    end

    tag_valid_d[0] = grant_valid;
    tag_idx_d[0]   = grant_idx;
    for (int s = 1; s < MEM_LATENCY; s++) begin
      tag_valid_d[s] = tag_valid_q[s-1];
      tag_idx_d[s]   = tag_idx_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q   <= '0;
      data_rdy_q  <= '0;
      data_q      <= '0;
      mem_re_q    <= 1'b0;
      mem_raddr_q <= '0;
      ptr_q       <= '0;
      tag_valid_q <= '0;
      for (int s = 0; s < MEM_LATENCY; s++) tag_idx_q[s] <= '0;
    end else begin
      pending_q   <= pending_d;
      data_rdy_q  <= data_rdy_d;
      data_q      <= data_d;
      mem_re_q    <= mem_re_d;
      mem_raddr_q <= mem_raddr_d;
      ptr_q       <= ptr_d;
      tag_valid_q <= tag_valid_d;
      for (int s = 0; s < MEM_LATENCY; s++) tag_idx_q[s] <= tag_idx_d[s];
    end
  end

  assign data      = data_q;
  assign data_rdy  = data_rdy_q;
  assign mem_re    = mem_re_q;
  assign mem_raddr = mem_raddr_q;

endmodule

// File: tb/tb_rr_read_arbiter.sv
// Bench for rr_read_arbiter: an 8-channel latency-1 instance and a 5-channel
// latency-3 instance, checked every cycle against a transaction-level model.
module tb_rr_read_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [7:0]   en0, req0, rdy0, rdata0, hold0;
  logic [103:0] addr0;
  logic [63:0]  data0;
  logic         re0;
  logic [12:0]  raddr0;

  logic [4:0]   en1, req1, rdy1;
  logic [64:0]  addr1;
  logic [39:0]  data1;
  logic         re1;
  logic [12:0]  raddr1, r1a, r1b;
  logic [7:0]   rdata1;

  function automatic logic [7:0] mem_f(input logic [12:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // BRAM models: latency 1 is combinational on the registered address,
  // latency 3 adds two more address stages.
  assign rdata0 = mem_f(raddr0);
  always @(posedge clk) begin
    r1a <= raddr1;
    r1b <= r1a;
  end
  assign rdata1 = mem_f(r1b);

  rr_read_arbiter #(.NUM_CHANNELS(8), .ADDRESS_WIDTH(13), .DATA_WIDTH(8), .MEM_LATENCY(1)) u_dut0 (
    .clk(clk), .resetn(resetn), .chan_enable(en0), .data_req(req0), .data_addr(addr0),
    .data(data0), .data_rdy(rdy0), .mem_re(re0), .mem_raddr(raddr0), .mem_rdata(rdata0));

  rr_read_arbiter #(.NUM_CHANNELS(5), .ADDRESS_WIDTH(13), .DATA_WIDTH(8), .MEM_LATENCY(3)) u_dut1 (
    .clk(clk), .resetn(resetn), .chan_enable(en1), .data_req(req1), .data_addr(addr1),
    .data(data1), .data_rdy(rdy1), .mem_re(re1), .mem_raddr(raddr1), .mem_rdata(rdata1));

  // ---------------- transaction-level model ----------------
  bit          m_pend [2][16];
  bit          m_rdy  [2][16];
  int          m_due  [2][16];
  logic [12:0] m_iss  [2][16];
  logic [7:0]  m_data [2][16];
  logic [12:0] m_a    [2][16];
  int          m_ptr  [2];
  bit          m_re   [2];
  logic [12:0] m_raddr[2];
  int          m_cyc = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_re[i] = 1'b0; m_raddr[i] = '0;
      for (int c = 0; c < 16; c++) begin
        m_pend[i][c] = 1'b0; m_rdy[i][c] = 1'b0; m_due[i][c] = -1;
        m_iss[i][c] = '0; m_data[i][c] = '0;
      end
    end
  endtask

  task automatic model_step(input int i, input int n, input int ml,
                            input logic [15:0] req, input logic [15:0] en);
    int win = -1;
    for (int s = 0; s < n; s++) begin
      int c = (m_ptr[i] + s) % n;
      if (win < 0 && req[c] && en[c] && !m_pend[i][c] && !m_rdy[i][c]) win = c;
    end
    for (int c = 0; c < n; c++) begin
      m_rdy[i][c] = 1'b0;
      if (m_due[i][c] == m_cyc) begin
        m_rdy[i][c]  = 1'b1;
        m_data[i][c] = mem_f(m_iss[i][c]);
        m_pend[i][c] = 1'b0;
        m_due[i][c]  = -1;
      end
    end
    if (win >= 0) begin
      m_re[i]         = 1'b1;
      m_raddr[i]      = m_a[i][win];
      m_iss[i][win]   = m_a[i][win];
      m_pend[i][win]  = 1'b1;
      m_due[i][win]   = m_cyc + ml;
      m_ptr[i]        = (win + 1) % n;
    end else begin
      m_re[i] = 1'b0;
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      model_reset();
    end else begin
      m_cyc++;
      for (int k = 0; k < 16; k++) begin
        m_a[0][k] = (k < 8) ? addr0[k*13 +: 13] : '0;
        m_a[1][k] = (k < 5) ? addr1[k*13 +: 13] : '0;
      end
      model_step(0, 8, 1, {8'h00, req0}, {8'h00, en0});
      model_step(1, 5, 3, {11'h000, req1}, {11'h000, en1});
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int tb_cyc   = 0;
  int rdy_log0[$], rdy_cyc0[$], rdy_log1[$], rdy_cyc1[$];
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_now();
    logic [7:0]  e_rdy0;
    logic [63:0] e_data0;
    logic [4:0]  e_rdy1;
    logic [39:0] e_data1;
    for (int k = 0; k < 8; k++) begin
      e_rdy0[k] = m_rdy[0][k];
      e_data0[k*8 +: 8] = m_data[0][k];
    end
    for (int k = 0; k < 5; k++) begin
      e_rdy1[k] = m_rdy[1][k];
      e_data1[k*8 +: 8] = m_data[1][k];
    end
    check("rdy0", 64'(rdy0), 64'(e_rdy0));
    check("data0", data0, e_data0);
    check("re0", 64'(re0), 64'(m_re[0]));
    check("raddr0", 64'(raddr0), 64'(m_raddr[0]));
    check("rdy1", 64'(rdy1), 64'(e_rdy1));
    check("data1", 64'(data1), 64'(e_data1));
    check("re1", 64'(re1), 64'(m_re[1]));
    check("raddr1", 64'(raddr1), 64'(m_raddr[1]));
  endtask

  // One cycle: compare, then act as the requesters (drop or re-address on rdy).
  task automatic step();
    @(negedge clk);
    tb_cyc++;
    compare_now();
    for (int k = 0; k < 8; k++) if (rdy0[k]) begin
      rdy_log0.push_back(k); rdy_cyc0.push_back(tb_cyc);
      if (hold0[k]) addr0[k*13 +: 13] = addr0[k*13 +: 13] + 13'h011;
      else req0[k] = 1'b0;
    end
    for (int k = 0; k < 5; k++) if (rdy1[k]) begin
      rdy_log1.push_back(k); rdy_cyc1.push_back(tb_cyc);
      req1[k] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((req0 != 0 || req1 != 0) && n < max_cycles) begin
      step();
      n++;
    end
    check("idle_timeout", 64'({req0, req1}), 64'd0);
    step();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    rdy_log0.delete(); rdy_cyc0.delete(); rdy_log1.delete(); rdy_cyc1.delete();
  endtask

  task automatic check_log(input string name, input int inst, input int start);
    for (int j = 0; j < exp_q.size(); j++) begin
      int got = -1;
      if (inst == 0) begin
        if (start + j < rdy_log0.size()) got = rdy_log0[start + j];
      end else begin
        if (start + j < rdy_log1.size()) got = rdy_log1[start + j];
      end
      check(name, 64'(got), 64'(exp_q[j]));
    end
  endtask

  initial begin
    int c0, cnt2, cnt6, gap;
    en0 = 8'hFF; req0 = '0; addr0 = '0; hold0 = '0;
    en1 = 5'h1F; req1 = '0; addr1 = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("rst_rdy0", 64'(rdy0), 64'd0);
    check("rst_re0", 64'(re0), 64'd0);
    check("rst_raddr1", 64'(raddr1), 64'd0);
    step(); step();
    resetn = 1'b1;

    // Single request on ch3, latency 1.
    addr0[3*13 +: 13] = 13'h123;
    req0[3] = 1'b1;
    c0 = tb_cyc;
    step();
    check("t1_raddr", 64'(raddr0), 64'h123);
    check("t1_re", 64'(re0), 64'd1);
    step();
    check("t1_rdy", 64'(rdy0), 64'h08);
    check("t1_data3", 64'(data0[31:24]), 64'h86);
    check("t1_latency", 64'(tb_cyc - c0), 64'd2);
    wait_idle(10);

    // All eight channels at once: grants and completions in order, no gaps.
    do_reset();
    for (int k = 0; k < 8; k++) addr0[k*13 +: 13] = 13'(k * 64 + 7);
    req0 = 8'hFF;
    wait_idle(30);
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(4'(k));
    check_log("t2_order", 0, 0);
    gap = (rdy_cyc0.size() >= 8) ? rdy_cyc0[7] - rdy_cyc0[0] : -1;
    check("t2_gapless", 64'(gap), 64'd7);

    // ch0 and ch5 held high with new address on each rdy: strict alternation.
    do_reset();
    addr0[0 +: 13] = 13'h100;
    addr0[5*13 +: 13] = 13'h500;
    hold0 = 8'h21;
    req0 = 8'h21;
    repeat (12) step();
    hold0 = '0;
    req0 = '0;
    step(); step();
    exp_q = {4'd0, 4'd5, 4'd0, 4'd5, 4'd0, 4'd5};
    check_log("t3_alternate", 0, 0);

    // ch2 disabled; ch6 disabled while its read is in flight.
    do_reset();
    en0 = 8'hFB;
    addr0[2*13 +: 13] = 13'h222;
    addr0[6*13 +: 13] = 13'h666;
    hold0 = 8'h40;
    req0 = 8'h44;
    step();
    check("t4_raddr", 64'(raddr0), 64'h666);
    en0[6] = 1'b0;
    repeat (6) step();
    hold0 = '0;
    req0 = '0;
    step();
    cnt2 = 0; cnt6 = 0;
    foreach (rdy_log0[j]) begin
      if (rdy_log0[j] == 2) cnt2++;
      if (rdy_log0[j] == 6) cnt6++;
    end
    check("t4_ch6_once", 64'(cnt6), 64'd1);
    check("t4_ch2_never", 64'(cnt2), 64'd0);
    en0 = 8'hFF;

    // Five channels, latency 3: overlapped reads, then pointer wrap 4 -> 0.
    do_reset();
    for (int k = 0; k < 5; k++) addr1[k*13 +: 13] = 13'(k * 51 + 1);
    req1 = 5'h1F;
    c0 = tb_cyc;
    wait_idle(40);
    exp_q.delete();
    for (int k = 0; k < 5; k++) exp_q.push_back(4'(k));
    check_log("t5_order", 1, 0);
    check("t5_latency", 64'((rdy_cyc1.size() > 0) ? rdy_cyc1[0] - c0 : -1), 64'd4);
    gap = (rdy_cyc1.size() >= 5) ? rdy_cyc1[4] - rdy_cyc1[0] : -1;
    check("t5_gapless", 64'(gap), 64'd4);
    addr1[0 +: 13] = 13'h0AA;
    addr1[13 +: 13] = 13'h0BB;
    req1 = 5'h03;
    wait_idle(20);
    exp_q = {4'd0, 4'd1};
    check_log("t5_wrap", 1, 5);
    check("t5_data_ch0", 64'(data1[7:0]), 64'h0F);
    check("t5_data_ch1", 64'(data1[15:8]), 64'h1E);

    // Asynchronous reset with two reads in flight.
    addr1[2*13 +: 13] = 13'h0CC;
    addr1[3*13 +: 13] = 13'h0DD;
    req1 = 5'h0C;
    step(); step();
    #2 resetn = 1'b0;
    #1;
    check("t6_rdy1", 64'(rdy1), 64'd0);
    check("t6_re1", 64'(re1), 64'd0);
    check("t6_raddr1", 64'(raddr1), 64'd0);
    check("t6_data1", 64'(data1), 64'd0);
    check("t6_data0", data0, 64'd0);
    req1 = '0;
    step();
    resetn = 1'b1;
    rdy_log1.delete();
    repeat (8) step();
    check("t6_no_rdy", 64'(rdy_log1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
